// File: rtl/imul_arbiter.sv
// Round-robin two-port arbiter and settle-cycle sequencer for a shared 16x16 combinational multiplier.
// Optional build macro IMUL_ARB_ZERO_SKIP_EN: a zero operand finishes in one cycle without waiting on the multiplier.
module imul_arbiter #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  iReq,
  input  logic [15:0] iA0,
  input  logic [15:0] iB0,
  input  logic [15:0] iA1,
  input  logic [15:0] iB1,
  output logic [15:0] oMulA,
  output logic [15:0] oMulB,
  input  logic [31:0] iMulResult,
  output logic [31:0] oResult,
  output logic [1:0]  oDone,
  output logic [1:0]  oGrant,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rr_q, rr_d;
  logic [15:0] mulA_q, mulA_d;
  logic [15:0] mulB_q, mulB_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  grant_q, grant_d;

  // rr only breaks ties; a lone request always wins regardless of the pointer.
  logic        pickIdx;
  logic [1:0]  pickOneHot;
  logic [15:0] selA, selB;

  assign pickIdx    = (iReq == 2'b11) ? rr_q : iReq[1];
  assign pickOneHot = pickIdx ? 2'b10 : 2'b01;
  assign selA       = pickIdx ? iA1 : iA0;
  assign selB       = pickIdx ? iB1 : iB0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    mulA_d   = mulA_q;
    mulB_d   = mulB_q;
    result_d = result_q;
    done_d   = done_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (iReq != 2'b00) begin
          grant_d = pickOneHot;
          mulA_d  = selA;
          mulB_d  = selB;
          cnt_d   = CNT_INIT;
          rr_d    = ~pickIdx;
          state_d = WAIT;
`ifdef IMUL_ARB_ZERO_SKIP_EN
          if ((selA == 16'd0) || (selB == 16'd0)) begin
            result_d = 32'd0;
            done_d   = pickOneHot;
            state_d  = DONE;
          end
`endif
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = iMulResult;
          done_d   = grant_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_d  = 2'b00;
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rr_q     <= 1'b0;
      mulA_q   <= 16'd0;
      mulB_q   <= 16'd0;
      result_q <= 32'd0;
      done_q   <= 2'b00;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      mulA_q   <= mulA_d;
      mulB_q   <= mulB_d;
      result_q <= result_d;
      done_q   <= done_d;
      grant_q  <= grant_d;
    end
  end

  assign oMulA   = mulA_q;
  assign oMulB   = mulB_q;
  assign oResult = result_q;
  assign oDone   = done_q;
  assign oGrant  = grant_q;
  assign oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_imul_arbiter.sv
// Testbench for imul_arbiter: directed scenarios followed by randomized requester traffic,
// every cycle compared against a transaction-level reference model.
module tb_imul_arbiter;

  localparam int MC = 2;

  logic        Clock;
  logic        Reset;
  logic [1:0]  iReq;
  logic [15:0] iA0, iB0, iA1, iB1;
  logic [15:0] oMulA, oMulB;
  logic [31:0] iMulResult;
  logic [31:0] oResult;
  logic [1:0]  oDone;
  logic [1:0]  oGrant;
  logic        oBusy;

  int checks = 0;
  int errors = 0;

  // Reference model state: who owns the multiplier and how many edges have passed since its grant.
  int          mOwner = -1;
  int          mAge = 0;
  int          mRr = 0;
  logic [1:0]  expGrant = 2'b00;
  logic [1:0]  expDone = 2'b00;
  logic [31:0] expResult = 32'd0;
  logic [15:0] expMulA = 16'd0;
  logic [15:0] expMulB = 16'd0;

  imul_arbiter #(.MUL_CYCLES(MC)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iReq       (iReq),
    .iA0        (iA0),
    .iB0        (iB0),
    .iA1        (iA1),
    .iB1        (iB1),
    .oMulA      (oMulA),
    .oMulB      (oMulB),
    .iMulResult (iMulResult),
    .oResult    (oResult),
    .oDone      (oDone),
    .oGrant     (oGrant),
    .oBusy      (oBusy)
  );

  // Stand-in for the shared combinational multiplier.
  assign iMulResult = {16'h0000, oMulA} * {16'h0000, oMulB};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] req,
                               input logic [15:0] a0, input logic [15:0] b0,
                               input logic [15:0] a1, input logic [15:0] b1);
    Reset = rst;
    iReq  = req;
    iA0   = a0;
    iB0   = b0;
    iA1   = a1;
    iB1   = b1;
  endtask

  // One rising edge of the specified behaviour, driven by the inputs sampled at that edge.
  task automatic modelStep();
    int g;
    if (!Reset) begin
      mOwner = -1; mAge = 0; mRr = 0;
      expGrant = 2'b00; expDone = 2'b00; expResult = 32'd0;
      expMulA = 16'd0; expMulB = 16'd0;
    end else if (mOwner < 0) begin
      if (iReq != 2'b00) begin
        if (iReq == 2'b11) g = mRr;
        else               g = iReq[1] ? 1 : 0;
        mOwner   = g;
        mRr      = 1 - g;
        mAge     = 0;
        expGrant = (g == 1) ? 2'b10 : 2'b01;
        expMulA  = (g == 1) ? iA1 : iA0;
        expMulB  = (g == 1) ? iB1 : iB0;
`ifdef IMUL_ARB_ZERO_SKIP_EN
        if (expMulA == 16'd0 || expMulB == 16'd0) begin
          expResult = 32'd0;
          expDone   = expGrant;
          mAge      = MC;
        end
`endif
      end
    end else begin
      mAge++;
      if (mAge == MC) begin
        expResult = {16'h0000, expMulA} * {16'h0000, expMulB};
        expDone   = expGrant;
      end else if (mAge == MC + 1) begin
        expDone  = 2'b00;
        expGrant = 2'b00;
        mOwner   = -1;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge Clock);
    modelStep();
    #1;
    checkOutput("grant",  {30'd0, oGrant}, {30'd0, expGrant});
    checkOutput("done",   {30'd0, oDone},  {30'd0, expDone});
    checkOutput("result", oResult, expResult);
    checkOutput("mulA",   {16'd0, oMulA},  {16'd0, expMulA});
    checkOutput("mulB",   {16'd0, oMulB},  {16'd0, expMulB});
    checkOutput("busy",   {31'd0, oBusy},  {31'd0, (mOwner >= 0)});
  endtask

  function automatic logic [15:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [1:0]  reqBits;
    logic [15:0] opA [2];
    logic [15:0] opB [2];
    logic [1:0]  prevGrant;
    int          grantIdx;
    logic        rstNow;

    applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    stepCycle();
    stepCycle();

    // Single request, 3*5.
    applyStimulus(1'b1, 2'b01, 16'd3, 16'd5, 16'd0, 16'd0);
    stepCycle();
    checkOutput("t1_busy_g", {31'd0, oBusy}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("t1_done", {30'd0, oDone}, 32'd1);
    checkOutput("t1_result", oResult, 32'd15);
    applyStimulus(1'b1, 2'b00, 16'd3, 16'd5, 16'd0, 16'd0);
    stepCycle();
    stepCycle();

    // Simultaneous requests straight after reset: requester 0 first.
    applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    stepCycle();
    applyStimulus(1'b1, 2'b11, 16'hFFFF, 16'hFFFF, 16'd2, 16'd7);
    stepCycle();
    checkOutput("t2_grant0", {30'd0, oGrant}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("t2_result0", oResult, 32'hFFFE0001);
    applyStimulus(1'b1, 2'b10, 16'hFFFF, 16'hFFFF, 16'd2, 16'd7);
    stepCycle();
    stepCycle();
    checkOutput("t2_grant1", {30'd0, oGrant}, 32'd2);
    stepCycle();
    stepCycle();
    checkOutput("t2_done1", {30'd0, oDone}, 32'd2);
    checkOutput("t2_result1", oResult, 32'd14);
    applyStimulus(1'b1, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    stepCycle();
    stepCycle();

    // Both held continuously: four operations alternate.
    applyStimulus(1'b1, 2'b11, 16'd5, 16'd6, 16'd7, 16'd8);
    prevGrant = 2'b00;
    grantIdx  = 0;
    for (int i = 0; i < 4 * (MC + 2); i++) begin
      stepCycle();
      if (oGrant != 2'b00 && prevGrant == 2'b00) begin
        checkOutput("t3_alt_grant", {30'd0, oGrant}, (grantIdx % 2 == 1) ? 32'd2 : 32'd1);
        grantIdx++;
      end
      prevGrant = oGrant;
    end
    checkOutput("t3_grant_count", 32'(grantIdx), 32'd4);
    applyStimulus(1'b1, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    stepCycle();

    // Reset during WAIT aborts; the next request runs normally.
    applyStimulus(1'b1, 2'b01, 16'd9, 16'd9, 16'd0, 16'd0);
    stepCycle();
    applyStimulus(1'b0, 2'b01, 16'd9, 16'd9, 16'd0, 16'd0);
    stepCycle();
    checkOutput("t4_abort_busy", {31'd0, oBusy}, 32'd0);
    checkOutput("t4_abort_done", {30'd0, oDone}, 32'd0);
    applyStimulus(1'b1, 2'b01, 16'd4, 16'd4, 16'd0, 16'd0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("t4_result", oResult, 32'd16);
    applyStimulus(1'b1, 2'b00, 16'd4, 16'd4, 16'd0, 16'd0);
    stepCycle();
    stepCycle();

    // Zero operand.
    applyStimulus(1'b1, 2'b01, 16'd0, 16'd1234, 16'd0, 16'd0);
    stepCycle();
`ifndef IMUL_ARB_ZERO_SKIP_EN
    checkOutput("t5_no_early_done", {30'd0, oDone}, 32'd0);
    stepCycle();
    stepCycle();
`endif
    checkOutput("t5_done", {30'd0, oDone}, 32'd1);
    checkOutput("t5_result", oResult, 32'd0);
    applyStimulus(1'b1, 2'b00, 16'd0, 16'd1234, 16'd0, 16'd0);
    stepCycle();
    stepCycle();

    // Request dropped and operand changed right after the grant.
    applyStimulus(1'b1, 2'b01, 16'd6, 16'd7, 16'd0, 16'd0);
    stepCycle();
    applyStimulus(1'b1, 2'b00, 16'd100, 16'd7, 16'd0, 16'd0);
    stepCycle();
    stepCycle();
    checkOutput("t6_done", {30'd0, oDone}, 32'd1);
    checkOutput("t6_result", oResult, 32'd42);
    stepCycle();
    stepCycle();

    // Randomized traffic; requesters honour the done handshake but also drop and change operands mid-flight.
    reqBits = 2'b00;
    for (int r = 0; r < 2; r++) begin
      opA[r] = randOperand();
      opB[r] = randOperand();
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rstNow = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      for (int r = 0; r < 2; r++) begin
        if (reqBits[r] && expDone[r]) begin
          reqBits[r] = 1'b0;
        end else if (!reqBits[r] && $urandom_range(0, 2) == 0) begin
          reqBits[r] = 1'b1;
          opA[r] = randOperand();
          opB[r] = randOperand();
        end else if (reqBits[r] && $urandom_range(0, 29) == 0) begin
          reqBits[r] = 1'b0;
        end
        if ($urandom_range(0, 5) == 0) begin
          opA[r] = randOperand();
          opB[r] = randOperand();
        end
      end
      applyStimulus(rstNow, reqBits, opA[0], opB[0], opA[1], opB[1]);
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
